// File: rtl/sysid_probe_ctrl.sv
// Purpose: reads the system-ID slave (ID word, then timestamp word), latches both and flags matches.
// Latency: zero-wait slave with READ_LATENCY=0 -> done pulses 3 cycles after the launch cycle.
// Backpressure: avm_read held until !avm_waitrequest; TIMEOUT_CYCLES stalled cycles per read abort the probe.
module sysid_probe_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h5FA5_0018,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, FIN} state_t;

  localparam bit         ZERO_LAT = (READ_LATENCY == 0);
  // Counter loads L-1 on acceptance so that the capture lands L cycles later.
  localparam logic [2:0] LAT_LOAD = ZERO_LAT ? 3'd0 : 3'(READ_LATENCY - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        first_cycle;
  logic [15:0] stall_cnt;
  logic [2:0]  lat_cnt;
  logic        in_req;
  logic        launch, cap_id, cap_ts, to_hit;

  assign in_req = (state == REQ_ID) || (state == REQ_TS);

  // State register; reset aborts any probe in flight without a done pulse.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus bus strobes and capture enables.
  always_comb begin
    state_nxt   = state;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    done        = 1'b0;
    busy        = (state != IDLE);
    launch      = 1'b0;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    to_hit      = 1'b0;
    case (state)
      IDLE: begin
        if (start || (first_cycle && AUTO_START)) begin
          launch    = 1'b1;
          state_nxt = REQ_ID;
        end
      end
      REQ_ID: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          cap_id    = ZERO_LAT;
          state_nxt = ZERO_LAT ? REQ_TS : LAT_ID;
        end else if (stall_cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = FIN;
        end
      end
      LAT_ID: begin
        if (lat_cnt == 3'd0) begin
          cap_id    = 1'b1;
          state_nxt = REQ_TS;
        end
      end
      REQ_TS: begin
        avm_read    = 1'b1;
        avm_address = 1'b1;
        if (!avm_waitrequest) begin
          cap_ts    = ZERO_LAT;
          state_nxt = ZERO_LAT ? FIN : LAT_TS;
        end else if (stall_cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = FIN;
        end
      end
      LAT_TS: begin
        if (lat_cnt == 3'd0) begin
          cap_ts    = 1'b1;
          state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stall and latency counters, captured words and result flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      first_cycle <= 1'b1;
      stall_cnt   <= '0;
      lat_cnt     <= '0;
      id_value    <= '0;
      ts_value    <= '0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      first_cycle <= 1'b0;
      if (in_req && avm_waitrequest) stall_cnt <= stall_cnt + 16'd1;
      else                           stall_cnt <= '0;
      if (in_req && !avm_waitrequest) lat_cnt <= LAT_LOAD;
      else if (lat_cnt != 3'd0)       lat_cnt <= lat_cnt - 3'd1;
      if (cap_id) id_value <= avm_readdata;
      if (cap_ts) ts_value <= avm_readdata;
      if (launch) begin
        id_match    <= 1'b0;
        ts_match    <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (to_hit) timeout_err <= 1'b1;
      // An aborted probe leaves both match flags at the 0 set on launch.
      if (state == FIN && !timeout_err) begin
        id_match <= (id_value == EXPECTED_ID);
        ts_match <= (ts_value == EXPECTED_TS);
      end
    end
  end

endmodule
